// File: rtl/seq_signed_div_if.sv
// seq_signed_div_if
//   Handshake and data bundle for the iterative signed divider.
//   master : requester side (drives start/X/Y, observes status and results)
//   slave  : divider side (consumes start/X/Y, drives status and results)
//   Signals:
//     start        request, honoured only while ready=1
//     X, Y         signed dividend / divisor, captured on an accepted start
//     ready        divider idle and able to accept
//     busy         operation in progress
//     done         one-cycle pulse marking a fresh result
//     Q, R         signed quotient / remainder
//     div_by_zero  result came from a zero divisor
//     overflow     result came from -2^(WIDTH-1) / -1
interface seq_signed_div_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, X, Y,
    input  ready, busy, done, Q, R, div_by_zero, overflow
  );

  modport slave (
    input  start, X, Y,
    output ready, busy, done, Q, R, div_by_zero, overflow
  );
endinterface

// File: rtl/seq_signed_div.sv
// seq_signed_div
//   Iterative signed integer divider: X / Y -> Q, R (truncating toward zero,
//   remainder takes the sign of the dividend). A radix-2 restoring core works
//   on operand magnitudes, one quotient bit per cycle, then a fix-up cycle
//   applies signs. Latency from accepted start to done is WIDTH+2 edges for
//   every operand pair, including divide-by-zero and the overflow case.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous, active-high reset (wins over everything)
//     bus  seq_signed_div_if.slave: start/X/Y in; ready/busy/done/Q/R/flags out
module seq_signed_div #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  seq_signed_div_if.slave     bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Two's complement negation, truncated to WIDTH bits.
  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Unsigned magnitude of a signed operand. The result is read as unsigned,
  // so |-2^(WIDTH-1)| = 2^(WIDTH-1) is exact in WIDTH bits.
  function automatic logic [WIDTH-1:0] abs_mag(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1]) begin
      return neg(v);
    end else begin
      return v;
    end
  endfunction

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] p_r;      // partial remainder (always < 2^WIDTH)
  logic [WIDTH-1:0] a_r;      // dividend bits shift out the top, quotient bits shift in
  logic [WIDTH:0]   ymag_r;   // divisor magnitude, one guard bit wide
  logic             sx_r;
  logic             sy_r;
  logic             dz_r;
  logic             ov_r;

  logic             ready_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] q_out_r;
  logic [WIDTH-1:0] r_out_r;
  logic             dz_out_r;
  logic             ov_out_r;

  logic [WIDTH:0]   p_shift_s;
  logic [WIDTH-1:0] p_next_s;
  logic             qbit_s;
  logic [WIDTH-1:0] q_fix_s;
  logic [WIDTH-1:0] r_fix_s;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // The difference is taken in WIDTH bits: whenever it is used the true
  // result is below |Y| <= 2^(WIDTH-1), so the dropped carry is always zero.
  always_comb begin
    p_shift_s = {p_r, a_r[WIDTH-1]};
    p_next_s  = p_shift_s[WIDTH-1:0];
    qbit_s    = 1'b0;
    if (p_shift_s >= ymag_r) begin
      p_next_s = p_shift_s[WIDTH-1:0] - ymag_r[WIDTH-1:0];
      qbit_s   = 1'b1;
    end else begin
      p_next_s = p_shift_s[WIDTH-1:0];
      qbit_s   = 1'b0;
    end
  end

  // Sign fix-up. With a zero divisor the core still leaves |X| in p_r, so
  // the remainder path naturally yields R = X; only Q needs forcing to -1.
  always_comb begin
    q_fix_s = a_r;
    r_fix_s = p_r;
    if (dz_r) begin
      q_fix_s = {WIDTH{1'b1}};
    end else if (sx_r ^ sy_r) begin
      q_fix_s = neg(a_r);
    end else begin
      q_fix_s = a_r;
    end
    if (sx_r) begin
      r_fix_s = neg(p_r);
    end else begin
      r_fix_s = p_r;
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      cnt_r    <= {CW{1'b0}};
      p_r      <= {WIDTH{1'b0}};
      a_r      <= {WIDTH{1'b0}};
      ymag_r   <= {(WIDTH+1){1'b0}};
      sx_r     <= 1'b0;
      sy_r     <= 1'b0;
      dz_r     <= 1'b0;
      ov_r     <= 1'b0;
      ready_r  <= 1'b1;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      q_out_r  <= {WIDTH{1'b0}};
      r_out_r  <= {WIDTH{1'b0}};
      dz_out_r <= 1'b0;
      ov_out_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            // Per-operation flags are recomputed here; the visible flags
            // only change together with Q/R at the end of the operation.
            sx_r    <= bus.X[WIDTH-1];
            sy_r    <= bus.Y[WIDTH-1];
            a_r     <= abs_mag(bus.X);
            ymag_r  <= {1'b0, abs_mag(bus.Y)};
            dz_r    <= (bus.Y == {WIDTH{1'b0}});
            ov_r    <= (bus.X == MIN_NEG) && (bus.Y == {WIDTH{1'b1}});
            p_r     <= {WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= CALC;
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          // WIDTH shift/subtract steps, then one extra CALC cycle before FIX
          // so that the latency is WIDTH+2 edges.
          if (cnt_r == LAST_STEP) begin
            state_r <= FIX;
          end else begin
            p_r     <= p_next_s;
            a_r     <= {a_r[WIDTH-2:0], qbit_s};
            cnt_r   <= cnt_r + CNT_ONE;
            state_r <= CALC;
          end
        end
        FIX: begin
          q_out_r  <= q_fix_s;
          r_out_r  <= r_fix_s;
          dz_out_r <= dz_r;
          ov_out_r <= ov_r;
          done_r   <= 1'b1;
          busy_r   <= 1'b0;
          state_r  <= DONE;
        end
        DONE: begin
          done_r  <= 1'b0;
          ready_r <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          ready_r <= 1'b1;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready       = ready_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.Q           = q_out_r;
  assign bus.R           = r_out_r;
  assign bus.div_by_zero = dz_out_r;
  assign bus.overflow    = ov_out_r;

endmodule

// File: tb/tb_seq_signed_div.sv
// tb_seq_signed_div
//   Self-checking bench for seq_signed_div (WIDTH=8): directed vector table,
//   hand-written handshake/reset sequences and randomized operands compared
//   against a plain-arithmetic reference model.
module tb_seq_signed_div;

  localparam int W = 8;
  localparam int LAT = W + 2;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  seq_signed_div_if #(.WIDTH(W)) bus ();

  seq_signed_div #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ov;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: integer division of the signed values, plus the two
  // special cases defined for the divider.
  task automatic model(input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output logic dz, output logic ov);
    int xi;
    int yi;
    xi = int'($signed(x));
    yi = int'($signed(y));
    dz = (yi == 0);
    ov = (xi == -128) && (yi == -1);
    if (dz) begin
      q = 8'hFF;
      r = x;
    end else begin
      q = W'(xi / yi);
      r = W'(xi % yi);
    end
  endtask

  // Issue one operation and wait (bounded) for done. Called just after an edge.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, output int lat,
                        output logic stable);
    int n;
    logic [W-1:0] q0;
    logic [W-1:0] r0;
    n = 0;
    while (!bus.ready && n < 30) begin
      tick();
      n++;
    end
    q0 = bus.Q;
    r0 = bus.R;
    stable = 1'b1;
    bus.start = 1'b1;
    bus.X = x;
    bus.Y = y;
    tick();
    bus.start = 1'b0;
    bus.X = W'($urandom);
    bus.Y = W'($urandom);
    n = 0;
    while (!bus.done && n < 40) begin
      if (bus.Q !== q0 || bus.R !== r0) stable = 1'b0;
      tick();
      n++;
    end
    lat = n;
  endtask

  task automatic run_and_check(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                               input logic full);
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic edz;
    logic eov;
    int lat;
    logic stable;
    model(x, y, eq, er, edz, eov);
    run_op(x, y, lat, stable);
    check($sformatf("%s Q x=%0h y=%0h", tag, x, y), bus.Q, eq);
    check($sformatf("%s R x=%0h y=%0h", tag, x, y), bus.R, er);
    check($sformatf("%s dz x=%0h y=%0h", tag, x, y), bus.div_by_zero, edz);
    check($sformatf("%s ov x=%0h y=%0h", tag, x, y), bus.overflow, eov);
    check($sformatf("%s latency", tag), lat, LAT);
    if (full) begin
      check($sformatf("%s hold during calc", tag), stable, 1'b1);
      tick();
      check($sformatf("%s done width", tag), bus.done, 1'b0);
      check($sformatf("%s ready after done", tag), bus.ready, 1'b1);
    end
  endtask

  initial begin
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic edz;
    logic eov;
    logic [W-1:0] ax[$];
    logic [W-1:0] ay[$];
    int acc[$];
    int dones;
    logic prev_done;
    logic [W-1:0] ex;
    logic [W-1:0] ey;
    int ea;

    checks = 0;
    errors = 0;
    bus.start = 1'b0;
    bus.X = '0;
    bus.Y = '0;
    rst = 1'b1;

    vecs.push_back('{8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0});  // 100/7
    vecs.push_back('{8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0});  // -100/7
    vecs.push_back('{8'h64, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0});  // 100/-7
    vecs.push_back('{8'h9C, 8'hF9, 8'h0E, 8'hFE, 1'b0, 1'b0});  // -100/-7
    vecs.push_back('{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1});  // -128/-1
    vecs.push_back('{8'h80, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0});  // -128/1
    vecs.push_back('{8'h05, 8'h00, 8'hFF, 8'h05, 1'b1, 1'b0});  // 5/0
    vecs.push_back('{8'h06, 8'h03, 8'h02, 8'h00, 1'b0, 1'b0});  // 6/3
    vecs.push_back('{8'hFB, 8'h00, 8'hFF, 8'hFB, 1'b1, 1'b0});  // -5/0
    vecs.push_back('{8'h7F, 8'h80, 8'h00, 8'h7F, 1'b0, 1'b0});  // 127/-128
    vecs.push_back('{8'h80, 8'h80, 8'h01, 8'h00, 1'b0, 1'b0});  // -128/-128
    vecs.push_back('{8'h00, 8'h05, 8'h00, 8'h00, 1'b0, 1'b0});  // 0/5
    vecs.push_back('{8'h80, 8'h00, 8'hFF, 8'h80, 1'b1, 1'b0});  // -128/0
    vecs.push_back('{8'h80, 8'h7F, 8'hFF, 8'hFF, 1'b0, 1'b0});  // -128/127

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    check("reset ready", bus.ready, 1'b1);
    check("reset busy", bus.busy, 1'b0);
    check("reset done", bus.done, 1'b0);
    check("reset Q", bus.Q, 8'h00);
    check("reset R", bus.R, 8'h00);
    check("reset dz", bus.div_by_zero, 1'b0);
    check("reset ov", bus.overflow, 1'b0);

    // Directed vector table, expected values written out by hand
    for (int i = 0; i < vecs.size(); i++) begin
      int lat;
      logic stable;
      run_op(vecs[i].x, vecs[i].y, lat, stable);
      check($sformatf("vec%0d Q", i), bus.Q, vecs[i].q);
      check($sformatf("vec%0d R", i), bus.R, vecs[i].r);
      check($sformatf("vec%0d dz", i), bus.div_by_zero, vecs[i].dz);
      check($sformatf("vec%0d ov", i), bus.overflow, vecs[i].ov);
      check($sformatf("vec%0d latency", i), lat, LAT);
      check($sformatf("vec%0d hold during calc", i), stable, 1'b1);
      tick();
      check($sformatf("vec%0d done width", i), bus.done, 1'b0);
      check($sformatf("vec%0d ready after done", i), bus.ready, 1'b1);
    end

    // start held high with changing operands: only accepts while ready
    dones = 0;
    prev_done = 1'b0;
    for (int c = 0; c < 30; c++) begin
      bus.start = 1'b1;
      bus.X = W'($urandom);
      bus.Y = W'($urandom);
      if (bus.ready) begin
        ax.push_back(bus.X);
        ay.push_back(bus.Y);
        acc.push_back(c);
      end
      tick();
      if (prev_done) check("b2b ready after done", bus.ready, 1'b1);
      prev_done = bus.done;
      if (bus.done) begin
        dones++;
        if (ax.size() > 0) begin
          ex = ax.pop_front();
          ey = ay.pop_front();
          ea = acc.pop_front();
          model(ex, ey, eq, er, edz, eov);
          check("b2b Q", bus.Q, eq);
          check("b2b R", bus.R, er);
          check("b2b dz", bus.div_by_zero, edz);
          check("b2b latency", c - ea, LAT);
        end else begin
          check("b2b unexpected done", 1'b1, 1'b0);
        end
      end
    end
    bus.start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.done) begin
        dones++;
        if (ax.size() > 0) begin
          ex = ax.pop_front();
          ey = ay.pop_front();
          void'(acc.pop_front());
          model(ex, ey, eq, er, edz, eov);
          check("b2b drain Q", bus.Q, eq);
          check("b2b drain R", bus.R, er);
        end else begin
          check("b2b drain unexpected done", 1'b1, 1'b0);
        end
      end
    end
    check("b2b done count", dones, 3);
    check("b2b pending ops", ax.size(), 0);

    // Reset in the middle of CALC discards the operation
    run_and_check("pre-reset", 8'h64, 8'h07, 1'b1);
    bus.start = 1'b1;
    bus.X = 8'h55;
    bus.Y = 8'h03;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst ready", bus.ready, 1'b1);
    check("midrst busy", bus.busy, 1'b0);
    check("midrst Q", bus.Q, 8'h00);
    check("midrst R", bus.R, 8'h00);
    dones = 0;
    for (int c = 0; c < 15; c++) begin
      if (bus.done) dones++;
      tick();
    end
    check("midrst no done", dones, 0);
    run_and_check("post-reset", 8'h9C, 8'hF9, 1'b1);

    // Randomized operands against the reference model
    for (int i = 0; i < 600; i++) begin
      logic [W-1:0] rx;
      logic [W-1:0] ry;
      rx = W'($urandom);
      ry = W'($urandom);
      if (i % 50 == 0) ry = 8'h00;
      if (i % 97 == 0) begin
        rx = 8'h80;
        ry = 8'hFF;
      end
      run_and_check("rand", rx, ry, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
